ascon_op_ctrl: RTL

- Command sequencer sitting between the SPI/host register interface and the ascon core.
- Accepts host commands over a valid/ready handshake and does one of two things:
  - serially loads a 64-bit word into one of the core state registers S_0..S_4 through the core's shift port;
  - launches a core operation and waits for the core to return to idle.
- Reports busy, a one-cycle done pulse and a sticky error flag, with timeout and abort handling.

---
 rtl/ascon_op_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ascon_op_ctrl.sv
// Host command sequencer for the ascon core: serially loads 64-bit state words
// through the core shift port, or launches an operation and waits for completion.
module ascon_op_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SHIFT_LEN      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_type,
    input  logic [2:0]  cmd_op,
    input  logic [2:0]  cmd_sel,
    input  logic [63:0] cmd_data,
    input  logic        abort,
    input  logic        core_idle,
    output logic [2:0]  operation_mode,
    output logic        operation_ready,
    output logic        state_shift_en,
    output logic [2:0]  state_shift_sel,
    output logic        state_shift_lsb,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CW   = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
    localparam logic [7:0]  TMAX = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SHIFT, START, WAIT_BUSY, WAIT_IDLE, DONE
    } state_t;

    state_t         state, state_d;
    logic [63:0]    shreg, shreg_d;
    logic [CW-1:0]  bitcnt, bitcnt_d;
    logic [7:0]     timer, timer_d;
    logic [2:0]     sel, sel_d;
    logic [2:0]     mode, mode_d;
    logic           err_q, err_d;
    logic           accept;

    assign accept = cmd_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            timer  <= '0;
            sel    <= '0;
            mode   <= '0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_d;
            shreg  <= shreg_d;
            bitcnt <= bitcnt_d;
            timer  <= timer_d;
            sel    <= sel_d;
            mode   <= mode_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        shreg_d  = shreg;
        bitcnt_d = bitcnt;
        timer_d  = timer;
        sel_d    = sel;
        mode_d   = mode;
        err_d    = err_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    err_d = 1'b0;
                    if (!cmd_type) begin
                        if (cmd_sel > 3'd4) begin
                            err_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            sel_d    = cmd_sel;
                            shreg_d  = cmd_data;
                            bitcnt_d = CW'(SHIFT_LEN - 1);
                            state_d  = SHIFT;
                        end
                    end else if (cmd_op == 3'd0 || cmd_op > 3'd5 || !core_idle) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        mode_d  = cmd_op;
                        state_d = START;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shreg << 1;
                if (bitcnt == '0) begin
                    state_d = DONE;
                end else begin
                    bitcnt_d = bitcnt - 1'b1;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!core_idle) begin
                    timer_d = '0;
                    state_d = WAIT_IDLE;
                end else if (timer >= TMAX) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer + 8'd1;
                end
            end
            WAIT_IDLE: begin
                // core returning idle wins over a simultaneous timer expiry
                if (core_idle) begin
                    state_d = DONE;
                end else if (timer >= TMAX) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_d = timer + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort overrides every other transition, including timeouts
        if (abort && state != IDLE) begin
            state_d = IDLE;
            err_d   = 1'b1;
            mode_d  = '0;
        end
    end

    assign cmd_ready       = (state == IDLE);
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign err             = err_q;
    assign operation_mode  = mode;
    assign operation_ready = (state == START);
    assign state_shift_en  = (state == SHIFT);
    assign state_shift_sel = (state == SHIFT) ? sel : 3'd0;
    assign state_shift_lsb = (state == SHIFT) ? shreg[63] : 1'b0;

endmodule
